lcmq_reader_verify: RTL and testbench

LCMQ_READER_VERIFY -- requirements
Module: lcmq_reader_verify

---
 rtl/lcmq_pkg.sv | 29 ++
 rtl/gf2_dot.sv | 18 +
 rtl/lcmq_reader_verify.sv | 127 ++++++++++++
 tb/tb_lcmq_reader_verify.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcmq_pkg.sv
// ----------------------------------------------------------------------------
// lcmq_pkg
// Shared definitions for the LCMQ reader-side verifier.
//   M_DEF      : default key/challenge width in bits
//   N_DEF      : default response length in bits
//   THRESH_DEF : default maximum mismatch count that still accepts
//   CNT_W      : counter width for the default response length
//   state_t    : verifier FSM states
// ----------------------------------------------------------------------------
package lcmq_pkg;

    localparam int M_DEF      = 163;
    localparam int N_DEF      = 162;
    localparam int THRESH_DEF = 40;

    // A counter that must reach n (not just n-1) needs clog2(n+1) bits.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W = cnt_width(N_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DECIDE = 2'd2
    } state_t;

endpackage

// File: rtl/gf2_dot.sv
// ----------------------------------------------------------------------------
// gf2_dot
// Combinational inner product over GF(2): bitwise AND of two W-bit vectors
// followed by an XOR reduction.
//   a, b : operand vectors, ascending bit order [0:W-1]
//   p    : parity of (a AND b)
// ----------------------------------------------------------------------------
module gf2_dot #(
    parameter int W = 163
) (
    input  logic [0:W-1] a,
    input  logic [0:W-1] b,
    output logic         p
);

    assign p = ^(a & b);

endmodule

// File: rtl/lcmq_reader_verify.sv
// ----------------------------------------------------------------------------
// lcmq_reader_verify
// Reader-side check of a serial LCMQ tag response. On an accepted start the
// challenge B and key row C_k are captured. Each valid response bit is
// compared against the GF(2) dot product of the challenge and the current
// key rotation; mismatches are counted. After exactly N valid bits the
// verdict is produced: accept when the mismatch count is at most THRESH.
// All N bits are always consumed so the run time does not depend on the
// number of errors.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   start     : one-cycle request to begin, honoured only when idle
//   B, C_k    : challenge and key row, sampled on accepted start
//   rsp_valid : rsp_bit carries a response bit this cycle
//   rsp_bit   : serial response bit, first bit first
//   busy      : verification in progress (RUN or DECIDE)
//   done      : one-cycle verdict strobe
//   accept    : verdict, held until the next accepted start or reset
//   err_count : mismatch total, held alongside accept
// ----------------------------------------------------------------------------
module lcmq_reader_verify
    import lcmq_pkg::*;
#(
    parameter int M      = M_DEF,
    parameter int N      = N_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [0:M-1]             B,
    input  logic [0:M-1]             C_k,
    input  logic                     rsp_valid,
    input  logic                     rsp_bit,
    output logic                     busy,
    output logic                     done,
    output logic                     accept,
    output logic [$clog2(N+1)-1:0]   err_count
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_IDX   = CW'(N - 1);
    localparam logic [CW-1:0] THRESH_VAL = CW'(THRESH);

    state_t          state;
    state_t          state_next;
    logic [0:M-1]    b_reg;
    logic [0:M-1]    ckr;
    logic [0:M-1]    ckr_rot;
    logic [CW-1:0]   bit_cnt;
    logic [CW-1:0]   err_next;
    logic            expected;
    logic            last_bit;
    logic            consume;

    gf2_dot #(
        .W (M)
    ) u_dot (
        .a (b_reg),
        .b (ckr),
        .p (expected)
    );

    // Rotate right by one: element M-1 wraps to element 0.
    assign ckr_rot  = {ckr[M-1], ckr[0:M-2]};
    assign consume  = (state == RUN) && rsp_valid;
    assign last_bit = (bit_cnt == LAST_IDX);
    // At most N increments happen per run and CW holds N, so this cannot wrap.
    assign err_next = err_count + {{(CW-1){1'b0}}, expected ^ rsp_bit};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            b_reg     <= '0;
            ckr       <= '0;
            bit_cnt   <= '0;
            err_count <= '0;
            accept    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                b_reg     <= B;
                ckr       <= C_k;
                bit_cnt   <= '0;
                err_count <= '0;
                accept    <= 1'b0;
            end else if (consume) begin
                ckr       <= ckr_rot;
                bit_cnt   <= bit_cnt + 1'b1;
                err_count <= err_next;
                // Verdict is registered with the last bit so it is already
                // valid during the DECIDE cycle and then simply held.
                if (last_bit) begin
                    accept <= (err_next <= THRESH_VAL);
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (consume && last_bit) begin
                    state_next = DECIDE;
                end
            end
            DECIDE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcmq_reader_verify.sv
// ----------------------------------------------------------------------------
// tb_lcmq_reader_verify
// Directed, table-driven bench for lcmq_reader_verify with default
// parameters (M=163, N=162, THRESH=40). Expected response streams are
// hand-derived per key pattern:
//   kind 0 : B=2, C_k=2          -> stream 1,0,0,...
//   kind 1 : B=index0, C_k=1     -> stream 0,1,0,...
//   kind 2 : B=all ones, C_k=1   -> stream 1,1,1,...
// ----------------------------------------------------------------------------
module tb_lcmq_reader_verify;

    localparam int M  = 163;
    localparam int N  = 162;
    localparam int CW = 8;

    typedef struct {
        string        name;
        logic [0:M-1] b;
        logic [0:M-1] ck;
        int           kind;
        int           rsp_mode;
        int           flips;
        int           gap_pct;
        bit           mid_start;
        int           exp_err;
        bit           exp_acc;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [0:M-1]  B;
    logic [0:M-1]  C_k;
    logic          rsp_valid;
    logic          rsp_bit;
    logic          busy;
    logic          done;
    logic          accept;
    logic [CW-1:0] err_count;

    int checks;
    int errors;
    vec_t vecs[10];

    lcmq_reader_verify dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .B         (B),
        .C_k       (C_k),
        .rsp_valid (rsp_valid),
        .rsp_bit   (rsp_bit),
        .busy      (busy),
        .done      (done),
        .accept    (accept),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic bit correctBit(input int kind, input int k);
        case (kind)
            0:       return (k == 0);
            1:       return (k == 1);
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit rspBit(input vec_t v, input int k);
        bit flip;
        if (v.rsp_mode == 1) return 1'b1;
        if (v.rsp_mode == 2) return 1'b0;
        flip = (k >= 5) && (((k - 5) % 3) == 0) && (((k - 5) / 3) < v.flips);
        return correctBit(v.kind, k) ^ flip;
    endfunction

    // Runs one full verification from the vector and checks timing and verdict.
    task automatic applyStimulus(input vec_t v);
        int idx;
        int cyc;
        bit early_done;
        bit busy_drop;
        bit drive_valid;
        idx = 0;
        cyc = 0;
        early_done = 1'b0;
        busy_drop = 1'b0;
        @(negedge clk);
        B = v.b;
        C_k = v.ck;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({v.name, " busy after start"}, busy, 1);
        checkOutput({v.name, " accept cleared"}, accept, 0);
        while (idx < N) begin
            drive_valid = !(v.gap_pct > 0 && $urandom_range(99, 0) < v.gap_pct);
            start = v.mid_start && (cyc == 20);
            if (start) begin
                B = '1;
                C_k = '1;
            end
            rsp_valid = drive_valid;
            rsp_bit = drive_valid ? rspBit(v, idx) : 1'b1;
            if (drive_valid) idx++;
            cyc++;
            @(negedge clk);
            if (idx < N && done) early_done = 1'b1;
            if (!busy) busy_drop = 1'b1;
        end
        rsp_valid = 1'b0;
        rsp_bit = 1'b0;
        start = 1'b0;
        checkOutput({v.name, " no early done"}, early_done, 0);
        checkOutput({v.name, " busy held in run"}, busy_drop, 0);
        checkOutput({v.name, " done after last bit"}, done, 1);
        checkOutput({v.name, " err_count"}, err_count, v.exp_err);
        checkOutput({v.name, " accept"}, accept, v.exp_acc);
        @(negedge clk);
        checkOutput({v.name, " done one cycle"}, done, 0);
        checkOutput({v.name, " busy idle"}, busy, 0);
        checkOutput({v.name, " accept held"}, accept, v.exp_acc);
        checkOutput({v.name, " err_count held"}, err_count, v.exp_err);
    endtask

    initial begin
        logic [0:M-1] two;
        logic [0:M-1] one;
        logic [0:M-1] top;
        checks = 0;
        errors = 0;
        two = '0;
        two[M-2] = 1'b1;
        one = '0;
        one[M-1] = 1'b1;
        top = '0;
        top[0] = 1'b1;

        vecs[0] = '{"clean k0",     two, two, 0, 0, 0,  0,  1'b0, 0,   1'b1};
        vecs[1] = '{"ones k0",      two, two, 0, 1, 0,  0,  1'b0, 161, 1'b0};
        vecs[2] = '{"zeros k0",     two, two, 0, 2, 0,  0,  1'b0, 1,   1'b1};
        vecs[3] = '{"flip40",       two, two, 0, 0, 40, 0,  1'b0, 40,  1'b1};
        vecs[4] = '{"flip41",       two, two, 0, 0, 41, 0,  1'b0, 41,  1'b0};
        vecs[5] = '{"clean k2",     '1,  one, 2, 0, 0,  0,  1'b0, 0,   1'b1};
        vecs[6] = '{"zeros k2",     '1,  one, 2, 2, 0,  0,  1'b0, 162, 1'b0};
        vecs[7] = '{"clean k1",     top, one, 1, 0, 0,  0,  1'b0, 0,   1'b1};
        vecs[8] = '{"ones k1",      top, one, 1, 1, 0,  0,  1'b0, 161, 1'b0};
        vecs[9] = '{"gaps midstart", two, two, 0, 0, 0, 30, 1'b1, 0,   1'b1};

        reset = 1'b0;
        start = 1'b0;
        B = '0;
        C_k = '0;
        rsp_valid = 1'b0;
        rsp_bit = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset accept", accept, 0);
        checkOutput("reset err_count", err_count, 0);
        reset = 1'b1;

        // Response bits while idle must not disturb anything.
        rsp_valid = 1'b1;
        rsp_bit = 1'b1;
        repeat (3) @(negedge clk);
        rsp_valid = 1'b0;
        checkOutput("idle rsp ignored busy", busy, 0);
        checkOutput("idle rsp ignored err", err_count, 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        // Start pulsed during DECIDE is dropped.
        applyStimulus(vecs[4]);
        @(negedge clk);
        B = two;
        C_k = two;
        start = 1'b1;
        rsp_valid = 1'b0;
        // One cycle earlier: re-run to land start exactly on DECIDE.
        start = 1'b0;
        applyStimulus(vecs[2]);
        // applyStimulus leaves us one cycle past DECIDE; redo a run and hit DECIDE.
        @(negedge clk);
        B = two;
        C_k = two;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            rsp_valid = 1'b1;
            rsp_bit = correctBit(0, k);
            @(negedge clk);
        end
        rsp_valid = 1'b0;
        checkOutput("decide done", done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start in decide ignored", busy, 0);
        checkOutput("verdict after decide start", accept, 1);

        // Reset in idle clears a held accepting verdict.
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("idle reset accept", accept, 0);
        @(negedge clk);
        reset = 1'b1;

        // Reset mid-run after 50 bits with a nonzero error count.
        @(negedge clk);
        B = two;
        C_k = two;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            rsp_valid = 1'b1;
            rsp_bit = 1'b1;
            @(negedge clk);
        end
        rsp_valid = 1'b0;
        checkOutput("partial err_count", err_count, 49);
        reset = 1'b0;
        #1;
        checkOutput("midrun reset busy", busy, 0);
        checkOutput("midrun reset done", done, 0);
        checkOutput("midrun reset accept", accept, 0);
        checkOutput("midrun reset err_count", err_count, 0);
        @(negedge clk);
        reset = 1'b1;
        rsp_valid = 1'b1;
        rsp_bit = 1'b1;
        repeat (4) @(negedge clk);
        rsp_valid = 1'b0;
        checkOutput("after reset waits busy", busy, 0);
        checkOutput("after reset waits err", err_count, 0);
        applyStimulus(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
